// File: rtl/serial_parallel.sv
// Receive side of the single-wire serial link: waits for a 0 start bit, then
// shifts in bit_length+1 data bits MSB first and presents the word with a one-cycle strobe.
module serial_parallel #(
    parameter int PARALLEL_PORT_WIDTH = 15,
    parameter int BIT_LENGTH          = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           din,
    input  logic [BIT_LENGTH-1:0]          bit_length,
    output logic [PARALLEL_PORT_WIDTH-1:0] dout,
    output logic                           dv_out,
    output logic                           busy
);

    localparam int W = PARALLEL_PORT_WIDTH;

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_LENGTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]          shift_q, shift_d;
    logic [W-1:0]          dout_d;
    logic                  dv_d;
    logic                  busy_d;
    logic [W-1:0]          shifted;

    // Words longer than W simply push their earliest bits out of the top.
    assign shifted = {shift_q[W-2:0], din};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout;
        dv_d    = 1'b0;
        busy_d  = busy;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // bit_length is captured into the counter here, so later changes cannot disturb the frame.
                if (din == 1'b0 && bit_length != '0) begin
                    cnt_d   = bit_length;
                    shift_d = '0;
                    busy_d  = 1'b1;
                    state_d = RECEIVE;
                end
            end
            RECEIVE: begin
                shift_d = shifted;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    dout_d  = shifted;
                    dv_d    = 1'b1;
                    busy_d  = 1'b0;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout    <= '0;
            dv_out  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout    <= dout_d;
            dv_out  <= dv_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_parallel.sv
// Bench for serial_parallel: table of directed frames, hand-written corner sequences,
// then random frame streams compared with expectations derived from the frame contents.
module tb_serial_parallel;

    localparam int W  = 15;
    localparam int BL = 4;

    logic          clk;
    logic          rstn;
    logic          din;
    logic [BL-1:0] bit_length;
    logic [W-1:0]  dout;
    logic          dv_out;
    logic          busy;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_dout;

    serial_parallel #(.PARALLEL_PORT_WIDTH(W), .BIT_LENGTH(BL)) dut (
        .clk(clk),
        .rstn(rstn),
        .din(din),
        .bit_length(bit_length),
        .dout(dout),
        .dv_out(dv_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BL-1:0] bl;
        logic [15:0]   data;
        logic [W-1:0]  expect_word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // One clock: drive inputs, let the edge pass, then compare all outputs.
    task automatic cycle(input logic d, input logic [BL-1:0] bl, input logic exp_dv, input logic exp_busy);
        din        = d;
        bit_length = bl;
        @(posedge clk);
        #1;
        check("dv_out", {31'd0, dv_out}, {31'd0, exp_dv});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("dout", {17'd0, dout}, {17'd0, exp_dout});
    endtask

    // Sends gap idle cycles, a start bit, and n+1 data bits (data[n] first).
    // bit_length is scrambled during data bits; the frame must still use n.
    task automatic send_frame(input int n, input logic [15:0] data, input int gap);
        logic [15:0] word;
        for (int g = 0; g < gap; g++) cycle(1'b1, BL'($urandom), 1'b0, 1'b0);
        cycle(1'b0, BL'(n), 1'b0, n != 0);
        if (n == 0) return;
        word = data & 16'((32'd1 << (n + 1)) - 1);
        for (int i = n; i >= 0; i--) begin
            if (i == 0) begin
                exp_dout = word[W-1:0];
                cycle(data[i], BL'($urandom), 1'b1, 1'b0);
            end else begin
                cycle(data[i], BL'($urandom), 1'b0, 1'b1);
            end
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{bl: 4'd14, data: 16'h5A3C, expect_word: 15'h5A3C};
        vecs[1] = '{bl: 4'd3,  data: 16'h000B, expect_word: 15'h000B};
        vecs[2] = '{bl: 4'd15, data: 16'hABCD, expect_word: 15'h2BCD};
        vecs[3] = '{bl: 4'd1,  data: 16'h0002, expect_word: 15'h0002};
        vecs[4] = '{bl: 4'd7,  data: 16'hFFA5, expect_word: 15'h00A5};

        rstn       = 1'b0;
        din        = 1'b1;
        bit_length = 4'd0;
        exp_dout   = '0;
        #12;
        check("reset dout", {17'd0, dout}, 32'd0);
        check("reset dv_out", {31'd0, dv_out}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Idle line with a non-zero length must never start a frame.
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'd14, 1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            send_frame(int'(vecs[v].bl), vecs[v].data, 2);
            check("table word", {17'd0, dout}, {17'd0, vecs[v].expect_word});
        end

        // Empty frame: start bit with bit_length 0 leaves everything untouched.
        send_frame(0, 16'h0000, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'd0, 1'b0, 1'b0);
        check("empty frame hold", {17'd0, dout}, 32'h00A5);

        // Back-to-back frames, start bit directly after the last data bit.
        send_frame(14, 16'h1234, 1);
        check("b2b first", {17'd0, dout}, 32'h1234);
        send_frame(14, 16'h7FFF, 0);
        check("b2b second", {17'd0, dout}, 32'h7FFF);
        cycle(1'b1, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset after 5 of 15 data bits.
        cycle(1'b0, 4'd14, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'd14, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid reset dout", {17'd0, dout}, 32'd0);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset dv", {31'd0, dv_out}, 32'd0);
        exp_dout = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) cycle(1'b1, 4'd14, 1'b0, 1'b0);
        send_frame(14, 16'h0F0F, 0);
        check("post reset frame", {17'd0, dout}, 32'h0F0F);

        // Random frame streams of random length and spacing.
        for (int f = 0; f < 60; f++) begin
            send_frame(int'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 3)));
        end
        cycle(1'b1, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
